// File: rtl/uart_rx_oversampled.sv
// Oversampled, majority-voted UART receiver with FWFT word FIFO and sticky errors; UART_RX_PARITY_EN adds parity.
// Latency: word enters the FIFO on the edge closing the last stop bit's decision tick; errors flag on that same edge.
// Backpressure: rx_ready_i low holds the head word; frames arriving while full are dropped and flag overrun.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [1:0]                    cfg_bits_i,
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
    input  logic                          cfg_stop_bits_i,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          err_parity_o,
    output logic                          err_frame_o,
    output logic                          err_overrun_o,
    input  logic                          err_clr_i
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;

    logic                 sync1, sync2, rx_prev;
    logic                 rx_s;
    logic                 start_det;
    logic [DIV_WIDTH-1:0] div_cnt, div_m1;
    logic [SW-1:0]        samp_cnt;
    logic                 tick, at_decide, at_end;
    logic                 s_a, s_b, voted;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic [7:0]           data_q;
    logic                 frame_bad;
    logic                 last_data, last_stop;
    logic                 push, set_frame;
    logic                 par_err_flag;

    // FIFO state
    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_empty, fifo_full, do_push, do_pop;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_i;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign rx_s      = sync2;
    assign start_det = (state_q == IDLE) && rx_prev && !rx_s;

    // Divider of 0 behaves as 1; >= keeps a mid-frame shrink from running away.
    assign div_m1    = (cfg_div_i == '0) ? '0 : cfg_div_i - DIV_WIDTH'(1);
    assign tick      = (state_q != IDLE) && (div_cnt >= div_m1);
    assign at_decide = tick && (samp_cnt == S_HI);
    assign at_end    = tick && (samp_cnt == S_LAST);
    assign voted     = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);

    assign last_data = (bit_cnt == ({1'b0, cfg_bits_i} + 3'd4));
    assign last_stop = (stop_cnt == cfg_stop_bits_i);

`ifdef UART_RX_PARITY_EN
    logic par_acc, par_err, par_bad, set_par;
    assign par_bad      = voted ^ par_acc ^ cfg_parity_odd_i;
    assign par_err_flag = par_err;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = cfg_parity_en_i ^ cfg_parity_odd_i;
    assign par_err_flag      = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
        set_par   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_det) state_d = START;
            end
            START: begin
                if (at_decide && voted) state_d = IDLE;
                else if (at_end)        state_d = DATA;
            end
            DATA: begin
                if (at_end && last_data) begin
`ifdef UART_RX_PARITY_EN
                    state_d = cfg_parity_en_i ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_decide && par_bad) set_par = 1'b1;
                if (at_end)               state_d = STOP;
            end
`endif
            STOP: begin
                // Leave at the final decision tick so the next start edge is caught early.
                if (at_decide) begin
                    if (!voted) set_frame = 1'b1;
                    if (last_stop) begin
                        state_d = IDLE;
                        push    = voted && !frame_bad && !par_err_flag;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            div_cnt   <= '0;
            samp_cnt  <= '0;
            s_a       <= 1'b0;
            s_b       <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            data_q    <= '0;
            frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc   <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else if (start_det) begin
            div_cnt   <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            data_q    <= '0;
            frame_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc   <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
            if (tick) samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + SW'(1);
            if (tick && (samp_cnt == S_LO))  s_a <= rx_s;
            if (tick && (samp_cnt == S_MID)) s_b <= rx_s;
            if ((state_q == DATA) && at_decide) begin
                data_q[bit_cnt] <= voted;
`ifdef UART_RX_PARITY_EN
                par_acc         <= par_acc ^ voted;
`endif
            end
            if ((state_q == DATA) && at_end) bit_cnt  <= bit_cnt + 3'd1;
            if ((state_q == STOP) && at_end) stop_cnt <= 1'b1;
            if (set_frame) frame_bad <= 1'b1;
`ifdef UART_RX_PARITY_EN
            if (set_par) par_err <= 1'b1;
`endif
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign do_pop     = rx_ready_i && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push    = push && (!fifo_full || do_pop);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!do_push && do_pop) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) fifo_mem[wr_ptr] <= data_q;
    end

    assign rx_valid_o   = !fifo_empty;
    assign rx_data_o    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign fifo_count_o = fifo_cnt;

    // Set has priority over clear.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            err_frame_o   <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            if (set_frame)      err_frame_o <= 1'b1;
            else if (err_clr_i) err_frame_o <= 1'b0;
            if (push && fifo_full && !do_pop) err_overrun_o <= 1'b1;
            else if (err_clr_i)               err_overrun_o <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            err_parity_o <= 1'b0;
        end else if (set_par) begin
            err_parity_o <= 1'b1;
        end else if (err_clr_i) begin
            err_parity_o <= 1'b0;
        end
    end
`else
    assign err_parity_o = 1'b0;
`endif

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Parametrised next-generation UART receive path for the apb_uart subsystem. It replaces single-sample bit detection with an oversampled, majority-voted receiver and supports 5–8 data bits, optional odd/even parity and 1 or 2 stop bits. Received words are buffered in a first-word-fall-through FIFO with a valid/ready read handshake. Parity, framing and overrun errors are reported as sticky flags. It sits between the rx_i pad and the APB register block, and contains its own baud tick generator.

## Interface
- OVERSAMPLE, 16: sample ticks per bit; even, ≥8.
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥2.
- DIV_WIDTH, 16: width of cfg_div_i.
- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- cfg_div_i  in  DIV_WIDTH  CLK cycles per sample tick; 0 is treated as 1.
- cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- cfg_parity_en_i  in  1  parity bit present.
- cfg_parity_odd_i  in  1  1=odd, 0=even parity.
- cfg_stop_bits_i  in  1  0=one stop bit, 1=two.
- rx_i  in  1  serial line; idles high.
- rx_data_o  out  8  FIFO head; right-aligned, zero-extended.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts the head word.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  entries held.
- err_parity_o / err_frame_o / err_overrun_o  out  1 each  sticky error flags.
- err_clr_i  in  1  clears all three sticky flags.

## Operation
- rx_i passes through a 2-FF synchroniser. Both FFs reset to 1.
- Start detection: a falling edge is the previous synced value 1 and the current value 0. A line held low never retriggers.
- Tick counter: counts 0..max(cfg_div_i,1)−1 and pulses tick on the terminal count. The sample counter counts ticks 0..OVERSAMPLE−1 within each bit. Both counters clear on start detect.
- Bit value: majority of the samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is made at tick OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge.
  - START: if the voted value is 1, return to IDLE (glitch rejected). Otherwise → DATA at end of bit.
  - DATA: shift LSB first. After cfg_bits_i+5 bits, go to PARITY if parity is enabled, else STOP.
  - PARITY: compare the received bit with the XOR of the data bits (inverted when odd). Record any mismatch.
  - STOP: each voted stop bit must be 1. After the last stop bit's decision tick, go directly to IDLE without waiting for end of bit, so the next start edge can resync.
- Frame completion:
  - Good frame: push the word to the FIFO.
  - Parity mismatch: set err_parity_o and drop the frame.
  - Stop bit = 0: set err_frame_o, drop the frame, and finish the remaining stop bit (if two) before IDLE.
- FIFO push and pop:
  - Pop on rx_valid_o & rx_ready_i.
  - Push while full with no same-cycle pop: drop the frame, set err_overrun_o, and leave FIFO contents untouched.
  - Push and pop in the same cycle while full: both succeed; count is unchanged.
- Error flags: sticky until err_clr_i. A set and a clear in the same cycle leaves the flag set.
- Config inputs are sampled continuously. Software changes them only while IDLE; a mid-frame change gives undefined data but no lock-up.

## Timing
- Reset values: rx_data_o=0, rx_valid_o=0, fifo_count_o=0, all error flags 0, FSM=IDLE, counters=0.
- Reset asserted mid-frame aborts immediately. The partial frame and all FIFO contents are lost.
- Bit period = OVERSAMPLE·max(cfg_div_i,1) CLK cycles.
- Latency:
  - Stop-bit decision tick to FIFO write: 1 CLK.
  - rx_valid_o and fifo_count_o update on the same edge as the write.
  - With an empty FIFO, rx_data_o is valid in that cycle.
- Pop: rx_data_o advances and fifo_count_o decrements on the edge where rx_valid_o & rx_ready_i was high.
- Error flags assert 1 CLK after the deciding tick.

## Configuration
- UART_RX_PARITY_EN defined: the parity checker and PARITY state are compiled in, and behave as above.
- UART_RX_PARITY_EN undefined:
  - PARITY state and checker are removed.
  - cfg_parity_en_i and cfg_parity_odd_i are ignored.
  - DATA always goes to STOP.
  - err_parity_o is tied to 0.
  - Ports remain present.

## Test plan
- 8N1, cfg_div_i=1, OVERSAMPLE=16, send 0xA5 → rx_valid_o=1, rx_data_o=0xA5, fifo_count_o=1, no error flags; pop with rx_ready_i=1 → count 0.
- 7E1 (cfg_bits_i=10), send 0x35 with parity bit forced to 1 → err_parity_o=1, FIFO empty; err_clr_i pulse → flag 0.
- 8N1, send 0x00 with stop bit 0 and line left low for 3 bit periods → err_frame_o=1, no push, no second frame detected until the line goes high then low.
- FIFO_DEPTH=8, rx_ready_i=0, send 0x01..0x09 → count=8, err_overrun_o=1; drain → 0x01..0x08 in order.
- 3-CLK low glitch on the idle line with cfg_div_i=1 → FSM returns to IDLE, no push, no errors.
- Assert RSTN low during data bit 4 → all outputs at reset values; after release, 0x3C received correctly.
